compressor_tree_pipe: RTL and testbench

COMPRESSOR_TREE_PIPE -- requirements
Module: compressor_tree_pipe

---
 rtl/compressor_tree_pipe_if.sv | 34 +++
 rtl/compressor_tree_pipe.sv | 133 +++++++++++++
 tb/tb_compressor_tree_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/compressor_tree_pipe_if.sv
// Operand/result stream bundle for compressor_tree_pipe; result_o exists only
// when COMPRESSOR_TREE_CPA_EN is defined.
interface compressor_tree_pipe_if #(
    parameter int NUM_IN   = 8,
    parameter int IN_SIZE  = 14,
    parameter int OUT_SIZE = 18
);
    logic                in_valid_i;
    logic                in_ready_o;
    logic [IN_SIZE-1:0]  in_i [NUM_IN];
    logic                out_valid_o;
    logic                out_ready_i;
    logic [OUT_SIZE-1:0] sum_o;
    logic [OUT_SIZE-1:0] carry_o;
`ifdef COMPRESSOR_TREE_CPA_EN
    logic [OUT_SIZE-1:0] result_o;
`endif

    modport master (
        output in_valid_i, in_i, out_ready_i,
`ifdef COMPRESSOR_TREE_CPA_EN
        input  result_o,
`endif
        input  in_ready_o, out_valid_o, sum_o, carry_o
    );

    modport slave (
        input  in_valid_i, in_i, out_ready_i,
`ifdef COMPRESSOR_TREE_CPA_EN
        output result_o,
`endif
        output in_ready_o, out_valid_o, sum_o, carry_o
    );
endinterface

// File: rtl/compressor_tree_pipe.sv
// Pipelined 4:2 compressor tree reducing NUM_IN signed operands to a sum/carry pair.
// Define COMPRESSOR_TREE_CPA_EN to add a registered carry-propagate stage (result_o).
module compressor_tree_pipe #(
    parameter int NUM_IN   = 8,
    parameter int IN_SIZE  = 14,
    parameter int OUT_SIZE = 18
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    compressor_tree_pipe_if.slave  bus
);
    localparam int unsigned LEVELS = $clog2(NUM_IN) - 1;
    localparam int unsigned W      = NUM_IN / 2;

    typedef logic [OUT_SIZE-1:0] vec_t;

    vec_t              stg_d [LEVELS][W];
    vec_t              stg_q [LEVELS][W];
    logic [LEVELS-1:0] vld_d;
    logic [LEVELS-1:0] vld_q;

    logic out_valid;
    logic stall;
    logic in_fire;

    function automatic vec_t sext(input logic [IN_SIZE-1:0] x);
        return OUT_SIZE'(signed'(x));
    endfunction

    // Two chained full-adder rows: a+b+c+d == s+k (mod 2^OUT_SIZE).
    function automatic logic [2*OUT_SIZE-1:0] compress42(input vec_t a, input vec_t b,
                                                         input vec_t c, input vec_t d);
        vec_t s1, k1, s, k;
        s1 = a ^ b ^ c;
        k1 = ((a & b) | (a & c) | (b & c)) << 1;
        s  = s1 ^ k1 ^ d;
        k  = ((s1 & k1) | (s1 & d) | (k1 & d)) << 1;
        return {s, k};
    endfunction

    assign stall          = out_valid && !bus.out_ready_i;
    assign bus.in_ready_o = !stall && !flush_i;
    assign in_fire        = bus.in_valid_i && bus.in_ready_o;

    always_comb begin
        vec_t                  src [NUM_IN];
        logic                  src_vld;
        logic [2*OUT_SIZE-1:0] pair;
        stg_d = stg_q;
        vld_d = vld_q;
        pair  = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) src[i] = sext(bus.in_i[i]);
        src_vld = in_fire;
        // Each level consumes the previous level's registers; src is refilled per level.
        for (int unsigned l = 0; l < LEVELS; l++) begin
            if (flush_i) begin
                vld_d[l] = 1'b0;
            end else if (!stall) begin
                vld_d[l] = src_vld;
                if (src_vld) begin
                    for (int unsigned g = 0; g < (NUM_IN >> (l + 2)); g++) begin
                        pair = compress42(src[4*g], src[4*g+1], src[4*g+2], src[4*g+3]);
                        stg_d[l][2*g]   = pair[2*OUT_SIZE-1:OUT_SIZE];
                        stg_d[l][2*g+1] = pair[OUT_SIZE-1:0];
                    end
                end
            end
            for (int unsigned i = 0; i < NUM_IN; i++) src[i] = '0;
            for (int unsigned i = 0; i < W; i++) src[i] = stg_q[l][i];
            src_vld = vld_q[l];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stg_q <= '{default: '0};
            vld_q <= '0;
        end else begin
            stg_q <= stg_d;
            vld_q <= vld_d;
        end
    end

`ifdef COMPRESSOR_TREE_CPA_EN
    vec_t cpa_sum_d, cpa_sum_q;
    vec_t cpa_carry_d, cpa_carry_q;
    vec_t result_d, result_q;
    logic cpa_vld_d, cpa_vld_q;

    always_comb begin
        cpa_sum_d   = cpa_sum_q;
        cpa_carry_d = cpa_carry_q;
        result_d    = result_q;
        cpa_vld_d   = cpa_vld_q;
        if (flush_i) begin
            cpa_vld_d = 1'b0;
        end else if (!stall) begin
            cpa_vld_d = vld_q[LEVELS-1];
            if (vld_q[LEVELS-1]) begin
                cpa_sum_d   = stg_q[LEVELS-1][0];
                cpa_carry_d = stg_q[LEVELS-1][1];
                result_d    = stg_q[LEVELS-1][0] + stg_q[LEVELS-1][1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpa_sum_q   <= '0;
            cpa_carry_q <= '0;
            result_q    <= '0;
            cpa_vld_q   <= 1'b0;
        end else begin
            cpa_sum_q   <= cpa_sum_d;
            cpa_carry_q <= cpa_carry_d;
            result_q    <= result_d;
            cpa_vld_q   <= cpa_vld_d;
        end
    end

    assign out_valid       = cpa_vld_q;
    assign bus.sum_o       = cpa_sum_q;
    assign bus.carry_o     = cpa_carry_q;
    assign bus.result_o    = result_q;
`else
    assign out_valid       = vld_q[LEVELS-1];
    assign bus.sum_o       = stg_q[LEVELS-1][0];
    assign bus.carry_o     = stg_q[LEVELS-1][1];
`endif

    assign bus.out_valid_o = out_valid;
endmodule

// File: tb/tb_compressor_tree_pipe.sv
// Directed bench for compressor_tree_pipe (NUM_IN=8, IN_SIZE=14, OUT_SIZE=18).
// Latency expectations follow COMPRESSOR_TREE_CPA_EN when it is defined.
module tb_compressor_tree_pipe;
    localparam int NUM_IN   = 8;
    localparam int IN_SIZE  = 14;
    localparam int OUT_SIZE = 18;
`ifdef COMPRESSOR_TREE_CPA_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    compressor_tree_pipe_if #(.NUM_IN(NUM_IN), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) bus ();

    compressor_tree_pipe #(.NUM_IN(NUM_IN), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [OUT_SIZE-1:0] tot_now();
        return OUT_SIZE'(bus.sum_o + bus.carry_o);
    endfunction

    task automatic set_all(input int val);
        for (int j = 0; j < NUM_IN; j++) bus.in_i[j] = IN_SIZE'(val);
    endtask

    // Drives one beat and waits LAT cycles; reports whether the output went valid early.
    task automatic run_beat(input logic [IN_SIZE-1:0] v [NUM_IN], output int early,
                            output logic fin_vld, output logic [OUT_SIZE-1:0] fin_tot,
                            output logic [OUT_SIZE-1:0] fin_res);
        early = 0;
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        for (int j = 0; j < NUM_IN; j++) bus.in_i[j] = v[j];
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            bus.in_valid_i = 1'b0;
            if (c < LAT && bus.out_valid_o) early++;
        end
        fin_vld = bus.out_valid_o;
        fin_tot = tot_now();
`ifdef COMPRESSOR_TREE_CPA_EN
        fin_res = bus.result_o;
`else
        fin_res = '0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        set_all(0);
        #12;
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
        n_checks++;
        if (bus.sum_o !== '0 || bus.carry_o !== '0) begin
            n_fail++; $display("FAIL reset_data: sum %0d carry %0d want 0 0", bus.sum_o, bus.carry_o);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
    endtask

    task automatic test_single(input string name, input int val_a, input int val_b,
                               input logic [OUT_SIZE-1:0] expect_tot);
        logic [IN_SIZE-1:0]  v [NUM_IN];
        int                  early;
        logic                vld;
        logic [OUT_SIZE-1:0] tot, res;
        for (int j = 0; j < NUM_IN; j++) v[j] = IN_SIZE'((j % 2 == 0) ? val_a : val_b);
        run_beat(v, early, vld, tot, res);
        n_checks++;
        if (early !== 0) begin n_fail++; $display("FAIL %s_early: valid %0d cycles too early", name, early); end
        n_checks++;
        if (vld !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b want 1", name, vld); end
        n_checks++;
        if (tot !== expect_tot) begin n_fail++; $display("FAIL %s_sum: got %0d want %0d", name, tot, expect_tot); end
    endtask

    task automatic test_max_operands();
        test_single("max", 8191, 8191, 18'd65528);
    endtask

    task automatic test_min_operands();
        test_single("min", -8192, -8192, 18'd196608);
    endtask

    task automatic test_mixed();
        test_single("mixed", 1, -1, 18'd0);
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcv  = 0;
        int low_ready = 0;
        int c = 0;
        logic exp_ready;
        logic [OUT_SIZE-1:0] exp_tot;
        while (rcv < 10 && c < 60) begin
            @(negedge clk);
            bus.out_ready_i = !(c >= 4 && c <= 8);
            bus.in_valid_i  = (sent < 10);
            for (int j = 0; j < NUM_IN; j++) bus.in_i[j] = IN_SIZE'(sent * 37 + j * 101 - 300);
            #1;
            exp_ready = !(c >= 4 && c <= 8);
            n_checks++;
            if (bus.in_ready_o !== exp_ready) begin
                n_fail++; $display("FAIL b2b_in_ready cycle %0d: got %b want %b", c, bus.in_ready_o, exp_ready);
            end
            if (!bus.in_ready_o) low_ready++;
            if (bus.out_valid_o) begin
                exp_tot = OUT_SIZE'(296 * rcv + 428);
                n_checks++;
                if (tot_now() !== exp_tot) begin
                    n_fail++; $display("FAIL b2b_data beat %0d cycle %0d: got %0d want %0d", rcv, c, tot_now(), exp_tot);
                end
                if (bus.out_ready_i) rcv++;
            end
            if (bus.in_valid_i && bus.in_ready_o) sent++;
            c++;
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        n_checks++;
        if (rcv !== 10) begin n_fail++; $display("FAIL b2b_count: got %0d want 10", rcv); end
        n_checks++;
        if (low_ready !== 5) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 5", low_ready); end
    endtask

    task automatic test_flush();
        int xfers = 0;
        @(negedge clk);
        flush = 1'b1; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready_idle: got %b want 0", bus.in_ready_o); end
        @(negedge clk); flush = 1'b0; bus.in_valid_i = 1'b1; set_all(5);
        @(negedge clk); set_all(7);
        @(negedge clk);
        flush = 1'b1; bus.out_ready_i = 1'b0; set_all(9);
        #1;
        n_checks++;
        if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready_o); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            flush = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
            #1;
            if (bus.out_valid_o) xfers++;
        end
        n_checks++;
        if (xfers !== 0) begin n_fail++; $display("FAIL flush_emitted: got %0d beats want 0", xfers); end
        test_single("post_flush", 3, 3, 18'd24);
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1; set_all(11);
        for (int c = 0; c < LAT; c++) @(negedge clk);
        #2;
        rst = 1'b1; bus.in_valid_i = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", bus.out_valid_o); end
        n_checks++;
        if (bus.sum_o !== '0 || bus.carry_o !== '0) begin
            n_fail++; $display("FAIL mid_reset_data: sum %0d carry %0d want 0 0", bus.sum_o, bus.carry_o);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b want 1", bus.in_ready_o); end
        for (int c = 0; c < LAT + 1; c++) begin
            n_checks++;
            if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_lost cycle %0d: got %b want 0", c, bus.out_valid_o); end
            @(negedge clk);
        end
    endtask

`ifdef COMPRESSOR_TREE_CPA_EN
    task automatic test_cpa();
        logic [IN_SIZE-1:0]  v [NUM_IN];
        int                  early;
        logic                vld;
        logic [OUT_SIZE-1:0] tot, res;
        for (int j = 0; j < NUM_IN; j++) v[j] = IN_SIZE'(j + 1);
        run_beat(v, early, vld, tot, res);
        n_checks++;
        if (early !== 0 || vld !== 1'b1) begin n_fail++; $display("FAIL cpa_latency: early %0d valid %b want 0 1", early, vld); end
        n_checks++;
        if (res !== 18'd36) begin n_fail++; $display("FAIL cpa_result: got %0d want 36", res); end
        n_checks++;
        if (tot !== 18'd36) begin n_fail++; $display("FAIL cpa_aligned: got %0d want 36", tot); end
    endtask
`endif

    initial begin
        test_reset();
        test_max_operands();
        test_min_operands();
        test_mixed();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
`ifdef COMPRESSOR_TREE_CPA_EN
        test_cpa();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
